axis_pixel_transform: RTL and testbench
=======================================

Name: axis_pixel_transform

Overview:
- Parametrised AXI4-Stream pixel-processing stage: N lanes of P-bit pixels per beat, selectable per-packet transform (pass, invert, threshold, inverted threshold).
- Sits between the DMA MM2S stream and the CNN input buffer; binarises and inverts MNIST frames before inference.
- Fully AXIS-compliant. Two-entry skid/output buffering gives full throughput under arbitrary backpressure, with no combinational ready path from master to slave.
- Carries TLAST and counts completed packets.

Parameters:
- PIXEL_WIDTH, 8, bits per pixel lane.
- LANES, 4, pixels per beat; data width = PIXEL_WIDTH*LANES.
- CNT_WIDTH, 16, width of packet counter.

Ports:
- axi_clk  in  1  clock, all logic on rising edge.
- axi_reset  in  1  synchronous, active-high reset.
- cfg_mode  in  2  transform: 0 pass, 1 invert, 2 threshold, 3 inverted threshold.
- cfg_threshold  in  PIXEL_WIDTH  threshold value for modes 2/3.
- s_axis_valid  in  1  slave valid.
- s_axis_data  in  PIXEL_WIDTH*LANES  slave data, lane i = bits [i*P +: P].
- s_axis_last  in  1  slave end-of-packet.
- s_axis_ready  out  1  slave ready.
- m_axis_valid  out  1  master valid.
- m_axis_data  out  PIXEL_WIDTH*LANES  transformed data.
- m_axis_last  out  1  master end-of-packet.
- m_axis_ready  in  1  master ready.
- pkt_count  out  CNT_WIDTH  packets completed on master side.
- busy  out  1  high while inside a packet (first beat accepted, last not yet accepted) on slave side.

Behaviour:
- Reset (synchronous, axi_reset=1 at clock edge) clears:
  - m_axis_valid=0, m_axis_data=0, m_axis_last=0.
  - Skid buffer empty; s_axis_ready=1 on the cycle after reset.
  - pkt_count=0, busy=0.
  - Latched config: mode=0, threshold=0.
  - Reset mid-packet discards all buffered beats; the next accepted beat is treated as a packet start.
- Handshakes:
  - Slave accept = s_axis_valid & s_axis_ready.
  - Master transfer = m_axis_valid & m_axis_ready.
- Config latching:
  - On accept with busy=0 (first beat), cfg_mode and cfg_threshold are sampled and latched.
  - That first beat uses the live inputs. All later beats of the packet use the latched values.
  - Config changes mid-packet have no effect until the next packet.
- Busy tracking:
  - busy set on a first-beat accept without last.
  - busy cleared on accept with s_axis_last=1.
  - A single-beat packet (last on first beat) leaves busy at 0.
- Per-lane transform, MAX = 2^P-1, unsigned:
  - Pass: p.
  - Invert: MAX-p.
  - Threshold: p >= thr ? MAX : 0.
  - Inverted threshold: p >= thr ? 0 : MAX.
  - Lanes are independent, with no carries between lanes.
- Buffering (output register OR plus skid register SK; each holds data, last, valid):
  - s_axis_ready = ~SK.valid (registered; no dependency on m_axis_ready in the same cycle).
  - On accept, the transformed beat goes to OR if OR is empty or a master transfer occurs this cycle and SK is empty; otherwise it goes to SK.
  - On master transfer with SK full: OR <- SK, SK empties.
  - On master transfer with SK empty and no accept: OR.valid <- 0.
- Latency and throughput:
  - Latency: a beat accepted in cycle n is visible on m_axis at n+1 when unstalled.
  - Throughput: one beat/cycle sustained with m_axis_ready=1.
- Stability: m_axis_data and m_axis_last hold stable while m_axis_valid=1 and m_axis_ready=0. Beats are never dropped, duplicated or reordered.
- pkt_count increments on master transfer with m_axis_last=1; wraps 2^CNT_WIDTH-1 -> 0.
- Simultaneous accept and master transfer with SK full cannot occur, because s_axis_ready=0 while SK is full.

Test Plan:
- Reset then P=8, L=4, mode 1, stream 0x00FF7F10 last=1, m_ready=1 -> m_axis_data=0xFF0080EF at next cycle, m_axis_last=1, pkt_count=1.
- Mode 2, thr=0x80, data 0x807F01FF -> 0xFF0000FF; mode 3 same data -> 0x00FFFF00.
- Mode change mid-packet: 3-beat packet starts mode 0, cfg_mode->1 after beat 1 -> all 3 beats pass unchanged; next packet inverted.
- Backpressure: continuous 8-beat valid stream with m_ready toggling 1,0,0,1,... -> s_axis_ready drops only with SK full; output sequence is identical to input order; data stable during stall.
- Counter wrap with CNT_WIDTH=2: 5 single-beat packets -> pkt_count 1,2,3,0,1; busy stays 0.
- axi_reset asserted with OR and SK full mid-packet -> next cycle m_axis_valid=0, s_axis_ready=1, busy=0; the next beat latches new cfg_mode.

Source files
------------

// File: rtl/axis_pixel_transform.sv
// axis_pixel_transform: per-packet pixel transform on an AXI4-Stream with output + skid buffering
// and a completed-packet counter on the master side.
module axis_pixel_transform #(
  parameter int PIXEL_WIDTH = 8,
  parameter int LANES = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                         axi_clk,
  input  logic                         axi_reset,
  input  logic [1:0]                   cfg_mode,
  input  logic [PIXEL_WIDTH-1:0]       cfg_threshold,
  input  logic                         s_axis_valid,
  input  logic [PIXEL_WIDTH*LANES-1:0] s_axis_data,
  input  logic                         s_axis_last,
  output logic                         s_axis_ready,
  output logic                         m_axis_valid,
  output logic [PIXEL_WIDTH*LANES-1:0] m_axis_data,
  output logic                         m_axis_last,
  input  logic                         m_axis_ready,
  output logic [CNT_WIDTH-1:0]         pkt_count,
  output logic                         busy
);
  localparam int DW = PIXEL_WIDTH*LANES;
  logic [DW-1:0] tx, sk_data;
  logic sk_last, sk_valid, accept, xfer;
  logic [1:0] mode_q, mode;
  logic [PIXEL_WIDTH-1:0] thr_q, thr;
  // The first beat of a packet sees the live config; later beats see the copy latched with it.
  assign mode = busy ? mode_q : cfg_mode;
  assign thr = busy ? thr_q : cfg_threshold;
  assign s_axis_ready = ~sk_valid;
  assign accept = s_axis_valid & s_axis_ready;
  assign xfer = m_axis_valid & m_axis_ready;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [PIXEL_WIDTH-1:0] p;
    logic ge;
    assign p = s_axis_data[i*PIXEL_WIDTH +: PIXEL_WIDTH];
    assign ge = p >= thr;
    assign tx[i*PIXEL_WIDTH +: PIXEL_WIDTH] = mode == 2'd0 ? p :
                                              mode == 2'd1 ? ~p :
                                              mode == 2'd2 ? {PIXEL_WIDTH{ge}} : {PIXEL_WIDTH{~ge}};
  end
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      m_axis_valid <= 1'b0;
      m_axis_data <= '0;
      m_axis_last <= 1'b0;
      sk_valid <= 1'b0;
      sk_data <= '0;
      sk_last <= 1'b0;
      pkt_count <= '0;
      busy <= 1'b0;
      mode_q <= 2'd0;
      thr_q <= '0;
    end else begin
      // An accept never coincides with a full skid, since ready is low then.
      if (xfer && sk_valid) begin
        m_axis_data <= sk_data;
        m_axis_last <= sk_last;
        sk_valid <= 1'b0;
      end else if (accept && (!m_axis_valid || xfer)) begin
        m_axis_valid <= 1'b1;
        m_axis_data <= tx;
        m_axis_last <= s_axis_last;
      end else if (accept) begin
        sk_valid <= 1'b1;
        sk_data <= tx;
        sk_last <= s_axis_last;
      end else if (xfer) begin
        m_axis_valid <= 1'b0;
      end
      if (accept && !busy) begin
        mode_q <= cfg_mode;
        thr_q <= cfg_threshold;
      end
      if (accept) busy <= ~s_axis_last;
      if (xfer && m_axis_last) pkt_count <= pkt_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_axis_pixel_transform.sv
// tb_axis_pixel_transform: directed vectors with hand-computed results; counter narrowed to 2 bits
// so wrap-around is reachable.
module tb_axis_pixel_transform;
  logic axi_clk = 1'b0, axi_reset = 1'b1;
  logic [1:0] cfg_mode = 2'd0;
  logic [7:0] cfg_threshold = 8'd0;
  logic s_valid = 1'b0, s_last = 1'b0, s_ready, m_valid, m_last, m_ready = 1'b0, busy;
  logic [31:0] s_data = '0, m_data;
  logic [1:0] pkt_count;
  int vectors = 0, errors = 0;

  axis_pixel_transform #(.PIXEL_WIDTH(8), .LANES(4), .CNT_WIDTH(2)) dut (
    .axi_clk(axi_clk), .axi_reset(axi_reset), .cfg_mode(cfg_mode), .cfg_threshold(cfg_threshold),
    .s_axis_valid(s_valid), .s_axis_data(s_data), .s_axis_last(s_last), .s_axis_ready(s_ready),
    .m_axis_valid(m_valid), .m_axis_data(m_data), .m_axis_last(m_last), .m_axis_ready(m_ready),
    .pkt_count(pkt_count), .busy(busy)
  );

  always #5 axi_clk = ~axi_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic l);
    s_valid = 1'b1;
    s_data = d;
    s_last = l;
    step();
    s_valid = 1'b0;
  endtask

  logic [31:0] q [8];
  logic [31:0] hold;
  logic stall;
  int in_i, out_i, occ, acc, xf;

  initial begin
    step();
    step();
    check("rst_mvalid", m_valid, 0);
    check("rst_mdata", m_data, 0);
    check("rst_cnt", pkt_count, 0);
    check("rst_busy", busy, 0);
    axi_reset = 1'b0;
    step();
    check("rst_sready", s_ready, 1);

    m_ready = 1'b1;
    cfg_mode = 2'd1;
    beat(32'h00FF7F10, 1'b1);
    check("inv_valid", m_valid, 1);
    check("inv_data", m_data, 32'hFF0080EF);
    check("inv_last", m_last, 1);
    step();
    check("inv_cnt", pkt_count, 1);
    check("inv_drain", m_valid, 0);

    cfg_mode = 2'd2;
    cfg_threshold = 8'h80;
    beat(32'h807F01FF, 1'b1);
    check("thr_data", m_data, 32'hFF0000FF);
    cfg_mode = 2'd3;
    beat(32'h807F01FF, 1'b1);
    check("ithr_data", m_data, 32'h00FFFF00);
    check("ithr_cnt", pkt_count, 2);

    cfg_mode = 2'd0;
    beat(32'h12345678, 1'b0);
    check("mid_b0", m_data, 32'h12345678);
    check("mid_cnt", pkt_count, 3);
    cfg_mode = 2'd1;
    beat(32'h9ABCDEF0, 1'b0);
    check("mid_b1", m_data, 32'h9ABCDEF0);
    check("mid_busy", busy, 1);
    beat(32'h0F1E2D3C, 1'b1);
    check("mid_b2", m_data, 32'h0F1E2D3C);
    check("mid_last", m_last, 1);
    check("mid_busy_end", busy, 0);
    beat(32'h12345678, 1'b1);
    check("next_inv", m_data, 32'hEDCBA987);
    check("wrap_cnt", pkt_count, 0);
    step();
    check("wrap_cnt2", pkt_count, 1);

    cfg_mode = 2'd0;
    for (int k = 0; k < 8; k++) q[k] = 32'hA0B0C0D0 + k * 32'h01010101;
    in_i = 0;
    out_i = 0;
    occ = 0;
    for (int c = 0; c < 40 && out_i < 8; c++) begin
      m_ready = (c % 4 == 0) || (c % 4 == 3);
      s_valid = in_i < 8;
      s_data = in_i < 8 ? q[in_i] : 32'h0;
      s_last = in_i == 7;
      check("bp_ready", s_ready, occ < 2);
      check("bp_valid", m_valid, occ > 0);
      acc = int'(s_valid & s_ready);
      xf = int'(m_valid & m_ready);
      if (xf != 0) begin
        check("bp_data", m_data, out_i < 8 ? q[out_i] : 32'h0);
        check("bp_last", m_last, out_i == 7);
        out_i++;
      end
      stall = m_valid & ~m_ready;
      hold = m_data;
      step();
      if (stall) check("bp_hold", m_data, hold);
      in_i += acc;
      occ += acc - xf;
    end
    s_valid = 1'b0;
    check("bp_beats", out_i, 8);

    m_ready = 1'b0;
    beat(32'h11111111, 1'b0);
    beat(32'h22222222, 1'b0);
    check("mr_full", s_ready, 0);
    axi_reset = 1'b1;
    step();
    axi_reset = 1'b0;
    check("mr_mvalid", m_valid, 0);
    check("mr_sready", s_ready, 1);
    check("mr_busy", busy, 0);
    check("mr_mdata", m_data, 0);
    cfg_mode = 2'd1;
    beat(32'h01020304, 1'b0);
    check("mr_first", m_data, 32'hFEFDFCFB);
    check("mr_busy2", busy, 1);
    m_ready = 1'b1;
    cfg_mode = 2'd0;
    beat(32'h10203040, 1'b1);
    check("mr_latched", m_data, 32'hEFDFCFBF);
    step();

    axi_reset = 1'b1;
    step();
    axi_reset = 1'b0;
    check("cw_rst", pkt_count, 0);
    for (int k = 0; k < 5; k++) begin
      beat(32'h55AA00FF ^ k, 1'b1);
      check("cw_cnt", pkt_count, k % 4);
      check("cw_busy", busy, 0);
    end
    step();
    check("cw_final", pkt_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
